// File: rtl/ceyloniac_boot_loader.sv
// CEYLONIAC boot sequencer: streams a program into RAM, preloads the register file,
// verifies the RAM image by checksum read-back, then releases the core from reset.
module ceyloniac_boot_loader #(
  parameter int RAM_DATA_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 32,
  parameter int NUM_INIT_REGS  = 4,
  parameter int LOAD_BASE_ADDR = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [RAM_ADDR_WIDTH-1:0] prog_len,
  input  logic [RAM_DATA_WIDTH-1:0] s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic                      ram_external_control_enable,
  output logic                      external_ram_enable,
  output logic                      external_ram_write_enable,
  output logic                      external_ram_read_enable,
  output logic [RAM_ADDR_WIDTH-1:0] external_ram_addr,
  output logic [RAM_DATA_WIDTH-1:0] external_ram_write_data,
  input  logic [RAM_DATA_WIDTH-1:0] external_ram_read_data,
  output logic                      reg_external_control_enable,
  output logic                      external_write_enable,
  output logic [REG_ADDR_WIDTH-1:0] external_write_addr,
  output logic [REG_DATA_WIDTH-1:0] external_write_data,
  output logic                      core_reset,
  output logic                      core_run,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [RAM_DATA_WIDTH-1:0] checksum
);

  localparam int RCW = REG_ADDR_WIDTH + 1;
  localparam logic [RAM_ADDR_WIDTH-1:0] LP_BASE  = RAM_ADDR_WIDTH'(LOAD_BASE_ADDR);
  localparam logic [RAM_ADDR_WIDTH-1:0] LP_AONE  = RAM_ADDR_WIDTH'(1);
  localparam logic [RCW-1:0]            LP_NREGS = RCW'(NUM_INIT_REGS);
  localparam logic [RCW-1:0]            LP_RONE  = RCW'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_RAM  = 3'd1,
    S_LOAD_REGS = 3'd2,
    S_VERIFY    = 3'd3,
    S_RELEASE   = 3'd4,
    S_DONE      = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  state_t r_state, w_state_nxt;
  logic [RAM_ADDR_WIDTH-1:0] r_len, w_len_nxt, r_cnt, w_cnt_nxt;
  logic [RCW-1:0]            r_rcnt, w_rcnt_nxt;
  logic [RAM_DATA_WIDTH-1:0] r_cksum, w_cksum_nxt, r_vsum, w_vsum_nxt;
  logic                      r_rd_pend;
  logic                      r_s_ready, w_s_ready;
  logic                      r_ram_ctrl, w_ram_ctrl;
  logic                      r_ram_we, w_ram_we, r_ram_re, w_ram_re;
  logic [RAM_ADDR_WIDTH-1:0] r_ram_addr, w_ram_addr;
  logic [RAM_DATA_WIDTH-1:0] r_ram_wdata, w_ram_wdata;
  logic                      r_reg_ctrl, w_reg_ctrl, r_reg_we, w_reg_we;
  logic [REG_ADDR_WIDTH-1:0] r_reg_addr, w_reg_addr;
  logic [REG_DATA_WIDTH-1:0] r_reg_wdata, w_reg_wdata;
  logic                      r_core_reset, w_core_reset, r_core_run, w_core_run;
  logic                      r_busy, w_busy, r_done, w_done, r_error, w_error;
  logic                      w_acc;

  assign w_acc = s_valid & r_s_ready;

  // Next-state, datapath and next-output decode; outputs are registered from the next state
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_rcnt_nxt  = r_rcnt;
    w_cksum_nxt = r_cksum;
    w_vsum_nxt  = r_vsum;
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_addr  = r_ram_addr;
    w_ram_wdata = r_ram_wdata;
    w_reg_we    = 1'b0;
    w_reg_addr  = r_reg_addr;
    w_reg_wdata = r_reg_wdata;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          w_len_nxt   = prog_len;
          w_cnt_nxt   = '0;
          w_rcnt_nxt  = '0;
          w_cksum_nxt = '0;
          w_vsum_nxt  = '0;
          if (prog_len != '0) begin
            w_state_nxt = S_LOAD_RAM;
          end else if (LP_NREGS != '0) begin
            w_state_nxt = S_LOAD_REGS;
          end else begin
            w_state_nxt = S_RELEASE;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_LOAD_RAM: begin
        if (w_acc) begin
          w_ram_we    = 1'b1;
          w_ram_addr  = LP_BASE + r_cnt;
          w_ram_wdata = s_data;
          w_cksum_nxt = r_cksum + s_data;
          if (r_cnt == r_len - LP_AONE) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (LP_NREGS != '0) ? S_LOAD_REGS : S_VERIFY;
          end else begin
            w_cnt_nxt = r_cnt + LP_AONE;
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      S_LOAD_REGS: begin
        if (w_acc) begin
          w_reg_we    = 1'b1;
          w_reg_addr  = r_rcnt[REG_ADDR_WIDTH-1:0];
          w_reg_wdata = s_data[REG_DATA_WIDTH-1:0];
          if (r_rcnt == LP_NREGS - LP_RONE) begin
            w_rcnt_nxt  = '0;
            w_state_nxt = (r_len == '0) ? S_RELEASE : S_VERIFY;
          end else begin
            w_rcnt_nxt = r_rcnt + LP_RONE;
          end
        end else begin
          w_rcnt_nxt = r_rcnt;
        end
      end
      S_VERIFY: begin
        if (r_cnt != r_len) begin
          w_ram_re   = 1'b1;
          w_ram_addr = LP_BASE + r_cnt;
          w_cnt_nxt  = r_cnt + LP_AONE;
        end else begin
          w_cnt_nxt = r_cnt;
        end
        // Read data lags its strobe by one cycle; the final datum decides the outcome.
        if (r_rd_pend) begin
          w_vsum_nxt = r_vsum + external_ram_read_data;
          if ((r_cnt == r_len) && !r_ram_re) begin
            w_state_nxt = (w_vsum_nxt == r_cksum) ? S_RELEASE : S_ERROR;
          end else begin
            w_state_nxt = S_VERIFY;
          end
        end else begin
          w_vsum_nxt = r_vsum;
        end
      end
      S_RELEASE: w_state_nxt = S_DONE;
      default:   w_state_nxt = S_IDLE;
    endcase

    w_s_ready    = (w_state_nxt == S_LOAD_RAM) || (w_state_nxt == S_LOAD_REGS);
    w_ram_ctrl   = (w_state_nxt == S_LOAD_RAM) || (w_state_nxt == S_VERIFY) || w_ram_we;
    w_reg_ctrl   = (w_state_nxt == S_LOAD_REGS) || w_reg_we;
    w_busy       = (w_state_nxt == S_LOAD_RAM) || (w_state_nxt == S_LOAD_REGS) ||
                   (w_state_nxt == S_VERIFY) || (w_state_nxt == S_RELEASE);
    w_done       = (w_state_nxt == S_DONE);
    w_error      = (w_state_nxt == S_ERROR);
    w_core_run   = w_done;
    w_core_reset = ~w_done;
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_cnt        <= '0;
      r_rcnt       <= '0;
      r_cksum      <= '0;
      r_vsum       <= '0;
      r_rd_pend    <= 1'b0;
      r_s_ready    <= 1'b0;
      r_ram_ctrl   <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_re     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_reg_ctrl   <= 1'b0;
      r_reg_we     <= 1'b0;
      r_reg_addr   <= '0;
      r_reg_wdata  <= '0;
      r_core_reset <= 1'b1;
      r_core_run   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_len        <= w_len_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rcnt       <= w_rcnt_nxt;
      r_cksum      <= w_cksum_nxt;
      r_vsum       <= w_vsum_nxt;
      r_rd_pend    <= r_ram_re;
      r_s_ready    <= w_s_ready;
      r_ram_ctrl   <= w_ram_ctrl;
      r_ram_we     <= w_ram_we;
      r_ram_re     <= w_ram_re;
      r_ram_addr   <= w_ram_addr;
      r_ram_wdata  <= w_ram_wdata;
      r_reg_ctrl   <= w_reg_ctrl;
      r_reg_we     <= w_reg_we;
      r_reg_addr   <= w_reg_addr;
      r_reg_wdata  <= w_reg_wdata;
      r_core_reset <= w_core_reset;
      r_core_run   <= w_core_run;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_error      <= w_error;
    end
  end

  assign s_ready                     = r_s_ready;
  assign ram_external_control_enable = r_ram_ctrl;
  assign external_ram_enable         = r_ram_ctrl;
  assign external_ram_write_enable   = r_ram_we;
  assign external_ram_read_enable    = r_ram_re;
  assign external_ram_addr           = r_ram_addr;
  assign external_ram_write_data     = r_ram_wdata;
  assign reg_external_control_enable = r_reg_ctrl;
  assign external_write_enable       = r_reg_we;
  assign external_write_addr         = r_reg_addr;
  assign external_write_data         = r_reg_wdata;
  assign core_reset                  = r_core_reset;
  assign core_run                    = r_core_run;
  assign busy                        = r_busy;
  assign done                        = r_done;
  assign error                       = r_error;
  assign checksum                    = r_cksum;

endmodule

// File: tb/tb_ceyloniac_boot_loader.sv
// Scoreboard bench: two loaders (base 1 and base FFFE) share one stimulus stream;
// the driver queues expected writes/reads, a negedge monitor pops and compares.
module tb_ceyloniac_boot_loader;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int RAW = 5;
  localparam int RDW = 32;
  localparam int NR = 4;
  localparam logic [31:0] PROG [6] = '{32'h20010005, 32'h20020003, 32'h00221820,
                                       32'hAC030000, 32'h8C040000, 32'h08000001};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, s_valid, corrupt;
  logic [AW-1:0] prog_len;
  logic [DW-1:0] s_data;
  logic s_ready [2], ram_ctrl [2], ram_en [2], ram_we [2], ram_re [2];
  logic [AW-1:0] ram_addr [2];
  logic [DW-1:0] ram_wdata [2], ram_rdata [2], cks [2];
  logic reg_ctrl [2], reg_we [2];
  logic [RAW-1:0] reg_addr [2];
  logic [RDW-1:0] reg_wdata [2];
  logic core_reset [2], core_run [2], busy [2], done [2], error [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ceyloniac_boot_loader #(
      .RAM_DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RAW),
      .REG_DATA_WIDTH(RDW), .NUM_INIT_REGS(NR), .LOAD_BASE_ADDR(g == 0 ? 1 : 65534)
    ) u_dut (
      .clk(clk), .reset(reset), .start(start), .prog_len(prog_len),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready[g]),
      .ram_external_control_enable(ram_ctrl[g]), .external_ram_enable(ram_en[g]),
      .external_ram_write_enable(ram_we[g]), .external_ram_read_enable(ram_re[g]),
      .external_ram_addr(ram_addr[g]), .external_ram_write_data(ram_wdata[g]),
      .external_ram_read_data(ram_rdata[g]),
      .reg_external_control_enable(reg_ctrl[g]), .external_write_enable(reg_we[g]),
      .external_write_addr(reg_addr[g]), .external_write_data(reg_wdata[g]),
      .core_reset(core_reset[g]), .core_run(core_run[g]), .busy(busy[g]),
      .done(done[g]), .error(error[g]), .checksum(cks[g])
    );
  end

  logic [DW-1:0] mem0 [0:65535];
  logic [DW-1:0] mem1 [0:65535];

  // Synchronous RAM models; instance 0 can corrupt address 3 on read-back
  always @(posedge clk) begin
    if (ram_en[0] && ram_we[0]) mem0[ram_addr[0]] <= ram_wdata[0];
    if (ram_en[0] && ram_re[0])
      ram_rdata[0] <= mem0[ram_addr[0]] ^ ((corrupt && ram_addr[0] == 16'd3) ? 32'h0000_0100 : 32'h0);
    if (ram_en[1] && ram_we[1]) mem1[ram_addr[1]] <= ram_wdata[1];
    if (ram_en[1] && ram_re[1]) ram_rdata[1] <= mem1[ram_addr[1]];
  end

  int n_chk = 0;
  int n_err = 0;
  int wr_k, reg_j;
  logic [47:0] q_wr [$];
  logic [15:0] q_rd [$];
  logic [36:0] q_reg [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a write or read strobe
  initial begin : mon
    logic pa;
    logic [47:0] ew;
    logic [15:0] er;
    logic [36:0] eg;
    pa = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pa = 1'b0;
      end else begin
        if (ram_we[0] || ram_we[1]) begin
          chk("wr_strobe_a", ram_we[0], 1);
          chk("wr_strobe_b", ram_we[1], 1);
          chk("wr_after_accept", pa, 1);
          chk("wr_port_owned", {ram_ctrl[0], ram_en[0], ram_ctrl[1], ram_en[1]}, 4'hF);
          chk("wr_expected", q_wr.size() != 0, 1);
          if (q_wr.size() != 0) begin
            ew = q_wr.pop_front();
            chk("wr_addr_a", ram_addr[0], AW'(16'd1 + ew[47:32]));
            chk("wr_addr_b", ram_addr[1], AW'(16'hFFFE + ew[47:32]));
            chk("wr_data_a", ram_wdata[0], ew[31:0]);
            chk("wr_data_b", ram_wdata[1], ew[31:0]);
          end
        end
        if (ram_re[0] || ram_re[1]) begin
          chk("rd_strobe_a", ram_re[0], 1);
          chk("rd_strobe_b", ram_re[1], 1);
          chk("rd_port_owned", {ram_ctrl[0], ram_en[0], ram_ctrl[1], ram_en[1]}, 4'hF);
          chk("rd_expected", q_rd.size() != 0, 1);
          if (q_rd.size() != 0) begin
            er = q_rd.pop_front();
            chk("rd_addr_a", ram_addr[0], AW'(16'd1 + er));
            chk("rd_addr_b", ram_addr[1], AW'(16'hFFFE + er));
          end
        end
        if (reg_we[0] || reg_we[1]) begin
          chk("rg_strobe_a", reg_we[0], 1);
          chk("rg_strobe_b", reg_we[1], 1);
          chk("rg_after_accept", pa, 1);
          chk("rg_port_owned", {reg_ctrl[0], reg_ctrl[1]}, 2'b11);
          chk("rg_expected", q_reg.size() != 0, 1);
          if (q_reg.size() != 0) begin
            eg = q_reg.pop_front();
            chk("rg_addr_a", reg_addr[0], eg[36:32]);
            chk("rg_addr_b", reg_addr[1], eg[36:32]);
            chk("rg_data_a", reg_wdata[0], eg[31:0]);
          end
        end
        if (pa) chk("accept_written", ram_we[0] | reg_we[0], 1);
        pa = s_valid && s_ready[0];
      end
    end
  end

  task automatic send(input logic [31:0] w, input bit is_prog, input bit bp);
    int t;
    if (bp) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data = w;
    t = 0;
    while (!s_ready[0] && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ready_in_time", s_ready[0], 1);
    @(posedge clk);
    if (is_prog) begin
      q_wr.push_back({16'(wr_k), w});
      wr_k++;
    end else begin
      q_reg.push_back({5'(reg_j), w});
      reg_j++;
    end
    #1;
    s_valid = 1'b0;
  endtask

  task automatic boot(input int len, input bit bp, input bit exp_err, input bit restart);
    logic [31:0] sum;
    int t;
    sum = 32'h0;
    wr_k = 0;
    reg_j = 0;
    prog_len = 16'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (restart) begin
      chk("restart_err_clr", error[0], 0);
      chk("restart_core_reset", core_reset[0], 1);
      chk("restart_busy", busy[0], 1);
    end
    for (int k = 0; k < len; k++) begin
      send(PROG[k], 1'b1, bp);
      sum = sum + PROG[k];
    end
    for (int j = 0; j < NR; j++) send(32'(j), 1'b0, bp);
    for (int k = 0; k < len; k++) q_rd.push_back(16'(k));
    t = 0;
    while (!done[1] && t < len + 4) begin
      @(posedge clk); #1;
      t++;
    end
    chk("done_in_time", done[1], 1);
    chk("core_reset_b", core_reset[1], 0);
    chk("checksum_a", cks[0], sum);
    chk("checksum_b", cks[1], sum);
    chk("busy_end", busy[0], 0);
    if (exp_err) begin
      chk("error_a", error[0], 1);
      chk("done_a_low", done[0], 0);
      chk("core_reset_held", core_reset[0], 1);
      chk("core_run_low", core_run[0], 0);
    end else begin
      chk("done_a", done[0], 1);
      chk("error_a_low", error[0], 0);
      chk("core_reset_a", core_reset[0], 0);
      chk("core_run_a", core_run[0], 1);
    end
    chk("queues_drained", q_wr.size() + q_rd.size() + q_reg.size(), 0);
    for (int k = 0; k < len; k++) begin
      chk("ram_a", mem0[AW'(1 + k)], PROG[k]);
      chk("ram_b", mem1[AW'(65534 + k)], PROG[k]);
    end
  endtask

  task automatic idle_outputs(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk({tag, "_strobes"}, {ram_we[g], ram_re[g], reg_we[g], ram_ctrl[g], ram_en[g], reg_ctrl[g]}, 6'h0);
      chk({tag, "_status"}, {s_ready[g], core_reset[g], core_run[g], busy[g], done[g], error[g]}, 6'b010000);
      chk({tag, "_checksum"}, cks[g], 0);
      chk({tag, "_ram_addr"}, ram_addr[g], 0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    prog_len = '0;
    corrupt = 1'b0;
    #12;
    idle_outputs("reset");
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    boot(6, 1'b0, 1'b0, 1'b0);
    chk("checksum_const", cks[0], 32'h802C1829);
    boot(6, 1'b1, 1'b0, 1'b0);
    corrupt = 1'b1;
    boot(6, 1'b0, 1'b1, 1'b0);
    corrupt = 1'b0;
    boot(6, 1'b0, 1'b0, 1'b1);
    boot(0, 1'b0, 1'b0, 1'b0);
    boot(4, 1'b0, 1'b0, 1'b0);

    wr_k = 0;
    reg_j = 0;
    prog_len = 16'd6;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) send(PROG[k], 1'b1, 1'b0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    idle_outputs("midreset");
    chk("midreset_queue", q_wr.size(), 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    boot(6, 1'b0, 1'b0, 1'b0);
    chk("reload_checksum", cks[0], 32'h802C1829);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ceyloniac_boot_loader.md
Name: ceyloniac_boot_loader

Overview:
- Hardware boot sequencer for the CEYLONIAC multi-cycle core.
- Accepts a valid/ready word stream and writes a program of prog_len words into RAM through the external RAM port.
- Then loads NUM_INIT_REGS initial register values through the external register-file port and reads RAM back to verify a checksum.
- Finally releases the core from reset and enables it, replacing bench-driven program and register preload with a reusable, parametrised block.

Parameters:
RAM_DATA_WIDTH, 32, RAM word width and stream data width
RAM_ADDR_WIDTH, 16, RAM address width; also the width of prog_len
REG_ADDR_WIDTH, 5, register-file address width
REG_DATA_WIDTH, 32, register data width (must be <= RAM_DATA_WIDTH; the low bits of the stream word are used)
NUM_INIT_REGS, 4, registers r0..r(N-1) initialised from the stream (0 to 2^REG_ADDR_WIDTH)
LOAD_BASE_ADDR, 1, RAM address of the first program word

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a boot sequence
prog_len  input  RAM_ADDR_WIDTH  program length in words; sampled on start
s_data  input  RAM_DATA_WIDTH  stream word
s_valid  input  1  stream word valid
s_ready  output  1  loader accepts a word
ram_external_control_enable  output  1  RAM port owned by the loader
external_ram_enable  output  1  RAM enable
external_ram_write_enable  output  1  RAM write strobe
external_ram_read_enable  output  1  RAM read strobe
external_ram_addr  output  RAM_ADDR_WIDTH  RAM address
external_ram_write_data  output  RAM_DATA_WIDTH  RAM write data
external_ram_read_data  input  RAM_DATA_WIDTH  RAM read data, valid 1 cycle after the read strobe
reg_external_control_enable  output  1  register-file port owned by the loader
external_write_enable  output  1  register write strobe
external_write_addr  output  REG_ADDR_WIDTH  register address
external_write_data  output  REG_DATA_WIDTH  register data
core_reset  output  1  active-high reset to the core
core_run  output  1  drives the core's control_enable, pc_enable and ram_enable
busy  output  1  sequence in progress
done  output  1  boot succeeded; core running
error  output  1  checksum mismatch
checksum  output  RAM_DATA_WIDTH  running modulo-2^RAM_DATA_WIDTH sum of the program words

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-sequence):
  - state IDLE; core_reset=1.
  - All other outputs 0: every enable, every strobe, all addresses and data, s_ready, busy, done, error, checksum.
- States: IDLE, LOAD_RAM, LOAD_REGS, VERIFY, RELEASE, DONE, ERROR.
- IDLE:
  - core_reset=1.
  - On start: latch prog_len, clear checksum and counters, set busy=1.
  - Go to LOAD_RAM, or to LOAD_REGS if prog_len=0.
- LOAD_RAM:
  - Outputs: ram_external_control_enable=1, external_ram_enable=1, s_ready=1.
  - A word is accepted on a cycle with s_valid&&s_ready. Word k appears next cycle on the RAM port: write strobe=1, addr=LOAD_BASE_ADDR+k (wraps modulo 2^RAM_ADDR_WIDTH), data=word.
  - The write strobe is 0 on cycles with no accept. The checksum adds each accepted word.
  - After the prog_len-th accept: go to LOAD_REGS, or to VERIFY if NUM_INIT_REGS=0.
- LOAD_REGS:
  - Outputs: reg_external_control_enable=1, s_ready=1.
  - Accepted word j is written the next cycle: external_write_enable=1, addr=j, data=low REG_DATA_WIDTH bits.
  - After NUM_INIT_REGS accepts, go to VERIFY. If prog_len=0, VERIFY is skipped and the next state is RELEASE.
- VERIFY:
  - s_ready=0.
  - Issue one read per cycle at LOAD_BASE_ADDR+k for k=0..prog_len-1, and sum read data one cycle later.
  - Once the last read datum has returned: if the sum equals checksum, go to RELEASE; otherwise go to ERROR.
- RELEASE (one cycle): all external control enables and strobes = 0; core_reset stays 1.
- DONE: core_reset=0, core_run=1, done=1, busy=0.
- ERROR: error=1, busy=0, core_reset=1, core_run=0.
- start is ignored in LOAD_RAM, LOAD_REGS, VERIFY and RELEASE.
- start in DONE or ERROR:
  - On the same edge: core_reset=1, core_run=0, done=0, error=0.
  - The new sequence then begins exactly as from IDLE.
- s_valid deasserted mid-load stalls the sequence indefinitely; no timeout.
- The write side of each transfer is registered: exactly one RAM or register write per accepted word, with no duplicates and no drops under back-to-back valid.

Test Plan:
- Nominal boot, 6 words. Stream 32'h20010005, 32'h20020003, 32'h00221820, 32'hAC030000, 32'h8C040000, 32'h08000001, then register words 0,1,2,3. Required: RAM[1..6] hold the words in order; r0..r3 = 0..3; checksum matches; done=1 and core_reset=0 within prog_len+4 cycles after the last accept.
- Back-pressure: toggle s_valid every other cycle. Required: exactly 6 RAM writes at addresses 1..6, each write strobe one cycle after its accept, and no gaps in addressing.
- Verify failure: the RAM model corrupts address 3 on read-back. Required: error=1, done=0, core_reset stays 1, core_run=0; a subsequent start clears error.
- prog_len=0 with NUM_INIT_REGS=4. Required: no RAM writes or reads; 4 register writes; then done=1.
- Address wrap: LOAD_BASE_ADDR=16'hFFFE, prog_len=4. Required: writes at FFFE, FFFF, 0000, 0001, and the verify reads use the same sequence.
- Reset mid-LOAD_RAM after 3 accepts. Required: all strobes drop to 0 immediately with core_reset=1; a fresh start reloads from LOAD_BASE_ADDR with checksum restarted at 0.
